// File: rtl/k2_program_loader.sv
// Program loader: downloads a WIDTH-bit instruction image into on-chip memory, then releases the processor.
// Latency: an accepted byte is written on the same edge; RUN is entered on the edge that accepts the last byte (or the check byte).
// Backpressure: byte_ready is high only in LOAD/CHECK; bytes offered in any other state are left unconsumed.
//
// Optional feature macro: K2_LOADER_CHECKSUM_EN -- when defined, a trailing check byte is compared
// against the 8-bit modulo-256 sum of the image and a mismatch parks the loader in ERROR.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   load_start                     single-cycle request to (re)start a download (IDLE/RUN/ERROR only)
//   byte_valid, byte_data          offered instruction byte
//   byte_ready                     loader accepts byte_data this cycle
//   ProgramAddress                 processor fetch address
//   instruction_data               mem[ProgramAddress] while in RUN, else 0
//   PC_en, proc_rst_n, halt        processor control: PC_en = RUN & ~halt, reset held outside RUN
//   load_done                      one-cycle pulse on the first cycle of RUN
//   load_error                     high while in ERROR

module k2_program_loader #(
    parameter int ADDR_BITS = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 byte_valid,
    input  logic [WIDTH-1:0]     byte_data,
    output logic                 byte_ready,
    input  logic [ADDR_BITS-1:0] ProgramAddress,
    output logic [WIDTH-1:0]     instruction_data,
    output logic                 PC_en,
    output logic                 proc_rst_n,
    input  logic                 halt,
    output logic                 load_done,
    output logic                 load_error
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ADDR_BITS-1:0]   wptr;
    logic [7:0]             checksum;
    logic                   load_done_q;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic                   accept;
    logic                   restart;
    logic [7:0]             byte_lo;

    assign byte_ready = (state == S_LOAD) || (state == S_CHECK);
    assign accept     = byte_valid && byte_ready;
    assign byte_lo    = 8'(byte_data);

    // load_start only counts when no download is in flight.
    assign restart = load_start &&
                     ((state == S_IDLE) || (state == S_RUN) || (state == S_ERROR));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (load_start) next_state = S_LOAD;
            end
            S_LOAD: begin
                if (accept && (wptr == LAST_ADDR)) begin
`ifdef K2_LOADER_CHECKSUM_EN
                    next_state = S_CHECK;
`else
                    next_state = S_RUN;
`endif
                end
            end
`ifdef K2_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) next_state = (byte_lo == checksum) ? S_RUN : S_ERROR;
            end
`endif
            S_RUN, S_ERROR: begin
                if (load_start) next_state = S_LOAD;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wptr        <= '0;
            checksum    <= '0;
            load_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state       <= next_state;
            // Pulse exactly on the edge that moves the loader into RUN.
            load_done_q <= (next_state == S_RUN) && (state != S_RUN);
            if (restart) begin
                wptr     <= '0;
                checksum <= '0;
            end else if ((state == S_LOAD) && accept) begin
                // wptr wraps to 0 on the last byte; LOAD is left on the same edge,
                // so no further writes can land.
                mem[wptr] <= byte_data;
                wptr      <= wptr + 1'b1;
                checksum  <= checksum + byte_lo;
            end
        end
    end

    assign instruction_data = (state == S_RUN) ? mem[ProgramAddress] : '0;
    assign proc_rst_n       = (state == S_RUN);
    assign PC_en            = (state == S_RUN) && !halt;
    assign load_done        = load_done_q;

`ifdef K2_LOADER_CHECKSUM_EN
    assign load_error = (state == S_ERROR);
`else
    assign load_error = 1'b0;
`endif

endmodule
